// File: rtl/bcd_subtractor_serial_if.sv
// Handshake/data bundle for bcd_subtractor_serial.
// master: requester driving start/a/b; slave: the subtractor.
interface bcd_subtractor_serial_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  start;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   diff;
  logic                  neg;
  logic                  err;

  modport master (
    output start, a, b,
    input  busy, done, diff, neg, err
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, neg, err
  );
endinterface

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = |a - b|, neg = (a < b).
// One digit per clock, LSB first. A final borrow triggers a second serial
// pass (COMP) that 10's-complements diff in place.
// Optional input validation: define BCD_SUB_INPUT_CHECK_EN.
module bcd_subtractor_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bcd_subtractor_serial_if.slave  bus
);
  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, SUB, COMP} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            borrow_q, borrow_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            neg_q, neg_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [3:0]      op_x, op_y, dig;
  logic [4:0]      t;
  logic            t_neg;

`ifdef BCD_SUB_INPUT_CHECK_EN
  logic            bad_q, bad_d;

  function automatic logic has_bad_digit(input logic [W-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (x[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction
`endif

  // One-digit subtract with borrow; COMP reuses it as 0 - diff[i] - borrow
  always_comb begin
    op_x = '0;
    op_y = '0;
    if (state_q == SUB) begin
      op_x = a_q[{idx_q, 2'b00} +: 4];
      op_y = b_q[{idx_q, 2'b00} +: 4];
    end else if (state_q == COMP) begin
      op_y = diff_q[{idx_q, 2'b00} +: 4];
    end
    t     = {1'b0, op_x} - {1'b0, op_y} - {4'b0000, borrow_q};
    t_neg = t[4];
    dig   = t_neg ? (t[3:0] + 4'd10) : t[3:0];
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    neg_d    = neg_q;
    err_d    = err_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef BCD_SUB_INPUT_CHECK_EN
    bad_d    = bad_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = 1'b0;
          idx_d    = '0;
          neg_d    = 1'b0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = SUB;
`ifdef BCD_SUB_INPUT_CHECK_EN
          bad_d    = has_bad_digit(bus.a) | has_bad_digit(bus.b);
`endif
        end
      end
      SUB: begin
`ifdef BCD_SUB_INPUT_CHECK_EN
        // Invalid operands spend exactly one SUB cycle, giving done at E1
        if (bad_q) begin
          diff_d  = '0;
          neg_d   = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          bad_d   = 1'b0;
          state_d = IDLE;
        end else
`endif
        begin
          diff_d[{idx_q, 2'b00} +: 4] = dig;
          borrow_d = t_neg;
          if (idx_q == LAST) begin
            if (t_neg) begin
              neg_d    = 1'b1;
              idx_d    = '0;
              borrow_d = 1'b0;
              state_d  = COMP;
            end else begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      COMP: begin
        diff_d[{idx_q, 2'b00} +: 4] = dig;
        borrow_d = t_neg;
        if (idx_q == LAST) begin
          borrow_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_SUB_INPUT_CHECK_EN
      bad_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BCD_SUB_INPUT_CHECK_EN
      bad_q    <= bad_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.neg  = neg_q;
  assign bus.err  = err_q;
endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Self-checking bench for bcd_subtractor_serial (DIGITS=4).
module tb_bcd_subtractor_serial;
  localparam int unsigned D = 4;
  localparam int unsigned W = 4 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bcd_subtractor_serial_if #(.DIGITS(D)) bus ();
  bcd_subtractor_serial #(.DIGITS(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Reference: decimal integers, absolute difference, re-pack to BCD
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int av, bv, dv;
    logic [3:0] da, db;
    av = 0; bv = 0;
    for (int i = int'(D) - 1; i >= 0; i--) begin
      da = a[i*4 +: 4];
      db = b[i*4 +: 4];
      av = av * 10 + int'(da);
      bv = bv * 10 + int'(db);
    end
    e.neg = (av < bv);
    dv    = e.neg ? (bv - av) : (av - bv);
    e.lat = e.neg ? 2 * int'(D) : int'(D);
    e.err = 1'b0;
    e.diff = '0;
    for (int i = 0; i < int'(D); i++) begin
      e.diff[i*4 +: 4] = 4'(dv % 10);
      dv = dv / 10;
    end
`ifdef BCD_SUB_INPUT_CHECK_EN
    for (int i = 0; i < int'(D); i++) begin
      da = a[i*4 +: 4];
      db = b[i*4 +: 4];
      if (da > 4'd9 || db > 4'd9) begin
        e.diff = '0; e.neg = 1'b0; e.err = 1'b1; e.lat = 1;
      end
    end
`endif
    return e;
  endfunction

  // Drive one start pulse, push the expectation, wait (bounded) for done.
  // lat = edges after the start-sampling edge; busy_cnt = busy-high cycles.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output bit got, output int lat, output int busy_cnt);
    got = 1'b0; lat = -1; busy_cnt = 0;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.start = 1'b1;
    sb.push_back(model(a, b));
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) got = 1'b1;
      else if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.diff !== '0)   begin errors++; $display("FAIL reset_diff got=%h exp=0", bus.diff); end
    checks++; if (bus.neg !== 1'b0)  begin errors++; $display("FAIL reset_neg got=%b exp=0", bus.neg); end
    checks++; if (bus.err !== 1'b0)  begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith;
    logic [W-1:0] ta [6] = '{16'h1234, 16'h0567, 16'h0000, 16'h9999, 16'h1000, 16'h0050};
    logic [W-1:0] tb [6] = '{16'h0567, 16'h1234, 16'h0001, 16'h9999, 16'h0001, 16'h0020};
    exp_t e;
    bit got; int lat, bc;
    for (int k = 0; k < 6; k++) begin
      run_op(ta[k], tb[k], got, lat, bc);
      e = sb.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL arith_done_timeout k=%0d got=no-done exp=done", k); end
      checks++; if (bus.diff !== e.diff) begin errors++; $display("FAIL arith_diff k=%0d got=%h exp=%h", k, bus.diff, e.diff); end
      checks++; if (bus.neg !== e.neg) begin errors++; $display("FAIL arith_neg k=%0d got=%b exp=%b", k, bus.neg, e.neg); end
      checks++; if (bus.err !== e.err) begin errors++; $display("FAIL arith_err k=%0d got=%b exp=%b", k, bus.err, e.err); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL arith_latency k=%0d got=%0d exp=%0d", k, lat, e.lat); end
      checks++; if (bc != e.lat) begin errors++; $display("FAIL arith_busy_cycles k=%0d got=%0d exp=%0d", k, bc, e.lat); end
    end
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    bit got = 1'b0; int lat = -1;
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h0567; bus.start = 1'b1;
    sb.push_back(model(16'h1234, 16'h0567));
    while (!got && lat < 40) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (lat == 0) bus.start = 1'b0;
      if (lat == 1) begin bus.a = 16'h9999; bus.b = 16'h0001; bus.start = 1'b1; end
      if (lat == 2) bus.start = 1'b0;
      if (bus.done) got = 1'b1;
    end
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL busy_ignore_timeout got=no-done exp=done"); end
    checks++; if (bus.diff !== e.diff) begin errors++; $display("FAIL busy_ignore_diff got=%h exp=%h", bus.diff, e.diff); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", lat, e.lat); end
    // No queued second operation; results hold while idle
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL hold_idle c=%0d got busy=%b done=%b exp=0/0", c, bus.busy, bus.done); end
      checks++; if (bus.diff !== e.diff || bus.neg !== e.neg) begin errors++; $display("FAIL hold_outputs c=%0d got=%h/%b exp=%h/%b", c, bus.diff, bus.neg, e.diff, e.neg); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] pa [4] = '{16'h0050, 16'h2000, 16'h0100, 16'h4321};
    logic [W-1:0] pb [4] = '{16'h0020, 16'h0001, 16'h0200, 16'h1234};
    exp_t e;
    bit got; int lat;
    @(negedge clk);
    bus.a = pa[0]; bus.b = pb[0]; bus.start = 1'b1;
    sb.push_back(model(pa[0], pb[0]));
    for (int k = 0; k < 4; k++) begin
      got = 1'b0; lat = -1;
      while (!got && lat < 40) begin
        @(posedge clk); lat++;
        @(negedge clk);
        if (lat == 0) begin
          checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept k=%0d got busy=%b exp=1", k, bus.busy); end
        end
        if (bus.done) got = 1'b1;
      end
      e = sb.pop_front();
      checks++; if (!got) begin errors++; $display("FAIL b2b_timeout k=%0d got=no-done exp=done", k); end
      checks++; if (bus.diff !== e.diff) begin errors++; $display("FAIL b2b_diff k=%0d got=%h exp=%h", k, bus.diff, e.diff); end
      checks++; if (bus.neg !== e.neg) begin errors++; $display("FAIL b2b_neg k=%0d got=%b exp=%b", k, bus.neg, e.neg); end
      checks++; if (lat != e.lat) begin errors++; $display("FAIL b2b_latency k=%0d got=%0d exp=%0d", k, lat, e.lat); end
      // Done cycle is IDLE: present the next pair so the coming edge accepts it
      if (k < 3) begin
        bus.a = pa[k+1]; bus.b = pb[k+1];
        sb.push_back(model(pa[k+1], pb[k+1]));
      end else begin
        bus.start = 1'b0;
      end
    end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    bit got; int lat, bc;
    @(negedge clk);
    bus.a = 16'h0567; bus.b = 16'h1234; bus.start = 1'b1;
    @(posedge clk);        // E0
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);        // E1
    @(posedge clk);        // E2
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.diff !== '0) begin errors++; $display("FAIL rstmid_diff got=%h exp=0", bus.diff); end
    checks++; if (bus.neg !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", bus.neg, bus.err); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done c=%0d got=%b exp=0", c, bus.done); end
    end
    run_op(16'h0050, 16'h0020, got, lat, bc);
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL rstmid_after_timeout got=no-done exp=done"); end
    checks++; if (bus.diff !== e.diff) begin errors++; $display("FAIL rstmid_after_diff got=%h exp=%h", bus.diff, e.diff); end
    checks++; if (bus.neg !== e.neg) begin errors++; $display("FAIL rstmid_after_neg got=%b exp=%b", bus.neg, e.neg); end
  endtask

  task automatic test_input_check;
`ifdef BCD_SUB_INPUT_CHECK_EN
    exp_t e;
    bit got; int lat, bc;
    run_op(16'h00A0, 16'h0001, got, lat, bc);
    e = sb.pop_front();
    checks++; if (!got) begin errors++; $display("FAIL chk_timeout got=no-done exp=done"); end
    checks++; if (lat != e.lat) begin errors++; $display("FAIL chk_latency got=%0d exp=%0d", lat, e.lat); end
    checks++; if (bus.err !== e.err) begin errors++; $display("FAIL chk_err got=%b exp=%b", bus.err, e.err); end
    checks++; if (bus.diff !== e.diff || bus.neg !== e.neg) begin errors++; $display("FAIL chk_result got=%h/%b exp=%h/%b", bus.diff, bus.neg, e.diff, e.neg); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL chk_busy got=%b exp=0", bus.busy); end
    run_op(16'h0050, 16'h0020, got, lat, bc);
    e = sb.pop_front();
    checks++; if (bus.err !== e.err) begin errors++; $display("FAIL chk_err_clear got=%b exp=%b", bus.err, e.err); end
    checks++; if (bus.diff !== e.diff) begin errors++; $display("FAIL chk_next_diff got=%h exp=%h", bus.diff, e.diff); end
`else
    @(negedge clk);
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL err_tied got=%b exp=0", bus.err); end
`endif
  endtask

  initial begin
    test_reset();
    test_arith();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_input_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
